// File: rtl/vga_pkg.sv
// Mode encodings and default 512x480 timing shared by the VGA output path.
package vga_pkg;
    localparam logic [1:0] MODE_NORMAL   = 2'b00;
    localparam logic [1:0] MODE_SCANLINE = 2'b01;
    localparam logic [1:0] MODE_DOUBLE   = 2'b10;
    localparam logic [1:0] MODE_BARS     = 2'b11;

    localparam int H_ACTIVE_DEF = 512;
    localparam int H_FP_DEF     = 23;
    localparam int H_SYNC_DEF   = 82;
    localparam int H_TOTAL_DEF  = 682;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_TOTAL_DEF  = 524;
    localparam int SYNC_POL_DEF = 0;
    localparam int CW_DEF       = 4;
    localparam int CNT_W_DEF    = 10;
endpackage

// File: rtl/vga_timing.sv
// Raster counters, registered h/v sync pulses and synchronous frame restart.
// Syncs lag the counter compare by one clock; no backpressure, free-running.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int SYNC_POL = SYNC_POL_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_i,
    output logic [CNT_W-1:0] h_o,
    output logic [CNT_W-1:0] v_o,
    output logic [CNT_W-1:0] h_next_o,
    output logic [CNT_W-1:0] v_next_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             frame_start_o
);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             SYNC_ACT = (SYNC_POL != 0);

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             hs_q, hs_d, vs_q, vs_d;

    always_comb begin
        h_d  = h_q + CNT_W'(1);
        v_d  = v_q;
        hs_d = hs_q;
        vs_d = vs_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
        end
        if (h_q == HS_START) hs_d = SYNC_ACT;
        if (h_q == HS_END)   hs_d = ~SYNC_ACT;
        // vsync edges are aligned to the hsync leading edge of the line
        if (h_q == HS_START) begin
            if (v_q == VS_START) vs_d = SYNC_ACT;
            if (v_q == VS_END)   vs_d = ~SYNC_ACT;
        end
        if (sync_i) begin
            h_d  = '0;
            v_d  = '0;
            hs_d = ~SYNC_ACT;
            vs_d = ~SYNC_ACT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q  <= '0;
            v_q  <= '0;
            hs_q <= ~SYNC_ACT;
            vs_q <= ~SYNC_ACT;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

    assign h_o           = h_q;
    assign v_o           = v_q;
    assign h_next_o      = h_d;
    assign v_next_o      = v_d;
    assign hsync_o       = hs_q;
    assign vsync_o       = vs_q;
    assign frame_start_o = (h_q == '0) && (v_q == '0);
endmodule

// File: rtl/vga_video_out.sv
// BGR555 to VGA output stage with scanline, line-double and test-bar modes.
// RGB is one clock behind pixel/h/v; no backpressure, pixel must be valid every clock.
module vga_video_out
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_TOTAL  = H_TOTAL_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_TOTAL  = V_TOTAL_DEF,
    parameter int SYNC_POL = SYNC_POL_DEF,
    parameter int CW       = CW_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic [1:0]       mode,
    input  logic             border,
    input  logic [14:0]      pixel,
    output logic             vga_h,
    output logic             vga_v,
    output logic [CW-1:0]    vga_r,
    output logic [CW-1:0]    vga_g,
    output logic [CW-1:0]    vga_b,
    output logic [CNT_W-1:0] vga_hcounter,
    output logic [CNT_W-1:0] vga_vcounter,
    output logic [CNT_W-1:0] next_pixel_x,
    output logic             frame_start
);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] BAR_W  = CNT_W'(H_ACTIVE / 8);

    logic [CNT_W-1:0] h_q, v_q, h_next, v_next;
    logic [1:0]       mode_q, mode_d;
    logic [CW-1:0]    r_q, r_d, g_q, g_d, b_q, b_d;
    logic [4:0]       r5, g5, b5;
    logic [2:0]       bar;
    logic             in_pic, on_border, bank;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_TOTAL(H_TOTAL),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_TOTAL(V_TOTAL),
        .SYNC_POL(SYNC_POL), .CNT_W(CNT_W)
    ) u_timing (
        .clk          (clk),
        .rst_n        (rst_n),
        .sync_i       (sync),
        .h_o          (h_q),
        .v_o          (v_q),
        .h_next_o     (h_next),
        .v_next_o     (v_next),
        .hsync_o      (vga_h),
        .vsync_o      (vga_v),
        .frame_start_o(frame_start)
    );

    // Mode only changes on the step into (0,0), which sync also forces.
    assign mode_d = ((h_next == '0) && (v_next == '0)) ? mode : mode_q;

    // Bank is taken from the line the fetched pixel belongs to; sync zeroes v_next.
    assign bank         = (mode_q == MODE_DOUBLE) ? v_next[1] : v_next[0];
    assign next_pixel_x = {bank, h_next[CNT_W-2:0]};

    assign bar       = 3'(h_q / BAR_W);
    assign in_pic    = (h_q < H_ACT) && (v_q < V_ACT);
    assign on_border = border && ((h_q == '0) || (h_q == H_ACT - CNT_W'(1)) ||
                                  (v_q == '0) || (v_q == V_ACT - CNT_W'(1)));

    always_comb begin
        r5 = pixel[4:0];
        g5 = pixel[9:5];
        b5 = pixel[14:10];
        if ((mode_q == MODE_SCANLINE) && v_q[0]) begin
            r5 = {1'b0, pixel[4:1]};
            g5 = {1'b0, pixel[9:6]};
            b5 = {1'b0, pixel[14:11]};
        end
        r_d = r5[4 -: CW];
        g_d = g5[4 -: CW];
        b_d = b5[4 -: CW];
        if (mode_q == MODE_BARS) begin
            r_d = {CW{bar[0]}};
            g_d = {CW{bar[1]}};
            b_d = {CW{bar[2]}};
        end
        if (on_border) begin
            r_d = '1;
            g_d = '1;
            b_d = '1;
        end
        if (!in_pic || sync) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_NORMAL;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
        end else begin
            mode_q <= mode_d;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
        end
    end

    assign vga_r        = r_q;
    assign vga_g        = g_q;
    assign vga_b        = b_q;
    assign vga_hcounter = h_q;
    assign vga_vcounter = v_q;
endmodule

// File: tb/tb_vga_video_out.sv
// Directed bench for vga_video_out; vertical timing shrunk to 14 lines so frames stay short.
module tb_vga_video_out;
    localparam int HT = 682;
    localparam int VT = 14;
    localparam int F  = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sync = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        border = 1'b0;
    logic [14:0] pixel = 15'h7FFF;
    logic        vga_h, vga_v, frame_start;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [9:0]  vga_hcounter, vga_vcounter, next_pixel_x;

    int checks = 0;
    int failures = 0;
    int bh = 0, bv = 0;

    always #5 clk = ~clk;

    vga_video_out #(
        .H_ACTIVE(512), .H_FP(23), .H_SYNC(82), .H_TOTAL(HT),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_TOTAL(VT),
        .SYNC_POL(0), .CW(4), .CNT_W(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .mode(mode), .border(border),
        .pixel(pixel), .vga_h(vga_h), .vga_v(vga_v), .vga_r(vga_r),
        .vga_g(vga_g), .vga_b(vga_b), .vga_hcounter(vga_hcounter),
        .vga_vcounter(vga_vcounter), .next_pixel_x(next_pixel_x),
        .frame_start(frame_start)
    );

    // One clock; bh/bv track where the raster should now be.
    task automatic step();
        @(negedge clk);
        if (sync) begin
            bh = 0;
            bv = 0;
        end else if (bh == HT - 1) begin
            bh = 0;
            bv = (bv == VT - 1) ? 0 : bv + 1;
        end else begin
            bh = bh + 1;
        end
    endtask

    task automatic goto(input int th, input int tv);
        int n;
        n = ((tv * HT + th) - (bv * HT + bh) + F) % F;
        repeat (n) step();
    endtask

    task automatic restart();
        sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (vga_hcounter !== 10'd0) begin failures++; $display("FAIL reset_h: got %0d want 0", vga_hcounter); end
        checks++; if (vga_vcounter !== 10'd0) begin failures++; $display("FAIL reset_v: got %0d want 0", vga_vcounter); end
        checks++; if (vga_h !== 1'b1 || vga_v !== 1'b1) begin failures++; $display("FAIL reset_syncs: got h=%b v=%b want 1 1", vga_h, vga_v); end
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin failures++; $display("FAIL reset_rgb: got %h want 000", {vga_r, vga_g, vga_b}); end
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL reset_fs: got %b want 1", frame_start); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bh = 0;
        bv = 0;
        step();
        checks++; if (vga_hcounter !== 10'd1 || vga_vcounter !== 10'd0) begin failures++; $display("FAIL release_count: got h=%0d v=%0d want 1 0", vga_hcounter, vga_vcounter); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL release_fs: got %b want 0", frame_start); end
    endtask

    task automatic test_frame();
        int hs_low = 0, vs_low = 0, hs_bad = 0, vs_bad = 0, fs_bad = 0;
        int fs_cnt = 0, fs_first = -1, first_hs_h = -1, first_vs_v = -1, first_vs_h = -1;
        logic exp_hs_low, exp_vs_low;
        mode = 2'b00; border = 1'b0; pixel = 15'h7FFF;
        restart();
        for (int i = 1; i <= 2 * F; i++) begin
            step();
            exp_hs_low = (bh >= 536) && (bh <= 617);
            exp_vs_low = (bv == 10 && bh >= 536) || (bv == 11) || (bv == 12 && bh <= 535);
            if (vga_h == 1'b0) begin
                hs_low++;
                if (first_hs_h < 0) first_hs_h = bh;
            end
            if (vga_v == 1'b0) begin
                vs_low++;
                if (first_vs_v < 0) begin first_vs_v = bv; first_vs_h = bh; end
            end
            if ((vga_h == 1'b0) != exp_hs_low) hs_bad++;
            if ((vga_v == 1'b0) != exp_vs_low) vs_bad++;
            if (frame_start !== (bh == 0 && bv == 0)) fs_bad++;
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = i;
            end
        end
        checks++; if (hs_low != 82 * 2 * VT) begin failures++; $display("FAIL hsync_low_total: got %0d want %0d", hs_low, 82 * 2 * VT); end
        checks++; if (first_hs_h != 536) begin failures++; $display("FAIL hsync_first_h: got %0d want 536", first_hs_h); end
        checks++; if (hs_bad != 0) begin failures++; $display("FAIL hsync_shape: got %0d wrong cycles want 0", hs_bad); end
        checks++; if (vs_low != 2 * 2 * HT) begin failures++; $display("FAIL vsync_low_total: got %0d want %0d", vs_low, 4 * HT); end
        checks++; if (first_vs_v != 10 || first_vs_h != 536) begin failures++; $display("FAIL vsync_start: got v=%0d h=%0d want 10 536", first_vs_v, first_vs_h); end
        checks++; if (vs_bad != 0) begin failures++; $display("FAIL vsync_shape: got %0d wrong cycles want 0", vs_bad); end
        checks++; if (fs_cnt != 2 || fs_first != F) begin failures++; $display("FAIL frame_period: got count=%0d first=%0d want 2 %0d", fs_cnt, fs_first, F); end
        checks++; if (fs_bad != 0) begin failures++; $display("FAIL frame_start_level: got %0d wrong cycles want 0", fs_bad); end
    endtask

    task automatic test_scanline();
        mode = 2'b01; border = 1'b0; pixel = 15'h7FFF;
        restart();
        goto(11, 1);
        checks++; if (vga_hcounter !== 10'd11 || vga_vcounter !== 10'd1) begin failures++; $display("FAIL scan_pos: got h=%0d v=%0d want 11 1", vga_hcounter, vga_vcounter); end
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h777) begin failures++; $display("FAIL scan_odd: got %h want 777", {vga_r, vga_g, vga_b}); end
        goto(11, 2);
        checks++; if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin failures++; $display("FAIL scan_even: got %h want fff", {vga_r, vga_g, vga_b}); end
        goto(601, 2);
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin failures++; $display("FAIL scan_blank: got %h want 000", {vga_r, vga_g, vga_b}); end
    endtask

    task automatic test_border();
        mode = 2'b00; border = 1'b1; pixel = 15'h0000;
        restart();
        for (int v = 0; v < 8; v++) begin
            goto(1, v);
            checks++; if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin failures++; $display("FAIL border_left v=%0d: got %h want fff", v, {vga_r, vga_g, vga_b}); end
            if (v == 3) begin
                goto(101, 3);
                checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin failures++; $display("FAIL border_inner: got %h want 000", {vga_r, vga_g, vga_b}); end
            end
            goto(512, v);
            checks++; if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin failures++; $display("FAIL border_right v=%0d: got %h want fff", v, {vga_r, vga_g, vga_b}); end
            if (v == 0) begin
                goto(601, 0);
                checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin failures++; $display("FAIL border_outside: got %h want 000", {vga_r, vga_g, vga_b}); end
            end
        end
        border = 1'b0;
    endtask

    task automatic test_bank();
        mode = 2'b10; pixel = 15'h7FFF;
        restart();
        goto(100, 1);
        checks++; if (next_pixel_x !== 10'h065) begin failures++; $display("FAIL bank_dbl_mid: got %h want 065", next_pixel_x); end
        goto(681, 1);
        checks++; if (next_pixel_x !== 10'h200) begin failures++; $display("FAIL bank_dbl_v1: got %h want 200", next_pixel_x); end
        goto(681, 3);
        checks++; if (next_pixel_x !== 10'h000) begin failures++; $display("FAIL bank_dbl_v3: got %h want 000", next_pixel_x); end
        sync = 1'b1;
        #1;
        checks++; if (next_pixel_x !== 10'h000) begin failures++; $display("FAIL bank_sync: got %h want 000", next_pixel_x); end
        step();
        sync = 1'b0;
        mode = 2'b00;
        restart();
        goto(100, 1);
        checks++; if (next_pixel_x !== 10'h265) begin failures++; $display("FAIL bank_norm_mid: got %h want 265", next_pixel_x); end
        goto(681, 1);
        checks++; if (next_pixel_x !== 10'h000) begin failures++; $display("FAIL bank_norm_v1: got %h want 000", next_pixel_x); end
    endtask

    task automatic test_mode_switch();
        mode = 2'b00; border = 1'b0; pixel = 15'h7FFF;
        restart();
        goto(0, 5);
        mode = 2'b11;
        goto(65, 5);
        checks++; if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin failures++; $display("FAIL switch_held: got %h want fff", {vga_r, vga_g, vga_b}); end
        goto(65, 0);
        checks++; if ({vga_r, vga_g, vga_b} !== 12'hF00) begin failures++; $display("FAIL bars_1: got %h want f00", {vga_r, vga_g, vga_b}); end
        goto(193, 0);
        checks++; if ({vga_r, vga_g, vga_b} !== 12'hFF0) begin failures++; $display("FAIL bars_3: got %h want ff0", {vga_r, vga_g, vga_b}); end
        goto(321, 0);
        checks++; if ({vga_r, vga_g, vga_b} !== 12'hF0F) begin failures++; $display("FAIL bars_5: got %h want f0f", {vga_r, vga_g, vga_b}); end
        goto(449, 0);
        checks++; if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin failures++; $display("FAIL bars_7: got %h want fff", {vga_r, vga_g, vga_b}); end
    endtask

    task automatic test_sync_reset();
        goto(300, 5);
        sync = 1'b1;
        step();
        sync = 1'b0;
        checks++; if (vga_hcounter !== 10'd0 || vga_vcounter !== 10'd0) begin failures++; $display("FAIL sync_pos: got h=%0d v=%0d want 0 0", vga_hcounter, vga_vcounter); end
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin failures++; $display("FAIL sync_rgb: got %h want 000", {vga_r, vga_g, vga_b}); end
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL sync_fs: got %b want 1", frame_start); end
        goto(600, 11);
        checks++; if (vga_h !== 1'b0 || vga_v !== 1'b0) begin failures++; $display("FAIL pre_sync_active: got h=%b v=%b want 0 0", vga_h, vga_v); end
        sync = 1'b1;
        step();
        sync = 1'b0;
        checks++; if (vga_h !== 1'b1 || vga_v !== 1'b1) begin failures++; $display("FAIL sync_syncs: got h=%b v=%b want 1 1", vga_h, vga_v); end
        checks++; if (vga_hcounter !== 10'd0 || vga_vcounter !== 10'd0) begin failures++; $display("FAIL sync_pos2: got h=%0d v=%0d want 0 0", vga_hcounter, vga_vcounter); end
        goto(300, 5);
        rst_n = 1'b0;
        #1;
        checks++; if (vga_hcounter !== 10'd0 || vga_vcounter !== 10'd0) begin failures++; $display("FAIL arst_pos: got h=%0d v=%0d want 0 0", vga_hcounter, vga_vcounter); end
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h000 || frame_start !== 1'b1) begin failures++; $display("FAIL arst_out: got rgb=%h fs=%b want 000 1", {vga_r, vga_g, vga_b}, frame_start); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bh = 0;
        bv = 0;
        goto(65, 0);
        checks++; if (vga_hcounter !== 10'd65 || vga_vcounter !== 10'd0) begin failures++; $display("FAIL arst_resume: got h=%0d v=%0d want 65 0", vga_hcounter, vga_vcounter); end
        checks++; if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin failures++; $display("FAIL arst_mode_cleared: got %h want fff", {vga_r, vga_g, vga_b}); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_scanline();
        test_border();
        test_bank();
        test_mode_switch();
        test_sync_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_video_out.md
VGA_VIDEO_OUT -- requirements
Module: vga_video_out

Interface
REQ-001 Parameters (name, default, meaning):
- H_ACTIVE, 512, visible pixels per line.
- H_FP, 23, horizontal front porch.
- H_SYNC, 82, hsync width.
- H_TOTAL, 682, clocks per line.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync width (lines).
- V_TOTAL, 524, lines per frame.
- SYNC_POL, 0, sync active level (0 = active-low).
- CW, 4, output bits per colour channel (1..5).
- CNT_W, 10, counter width.
- Constraints: H_ACTIVE <= 2^(CNT_W-1); H_TOTAL, V_TOTAL <= 2^CNT_W.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst_n, in, 1, asynchronous active-low reset.
- sync, in, 1, synchronous frame restart.
- mode, in, 2, 00 normal, 01 scanline, 10 line-double, 11 test bars.
- border, in, 1, draw white frame.
- pixel, in, 15, BGR555 pixel for the current h.
- vga_h, out, 1, hsync.
- vga_v, out, 1, vsync.
- vga_r / vga_g / vga_b, out, CW each, colour.
- vga_hcounter, out, CNT_W, h.
- vga_vcounter, out, CNT_W, v.
- next_pixel_x, out, CNT_W, {bank, x} fetch address for the next cycle.
- frame_start, out, 1, high while h==0 and v==0.

Function
REQ-003 h SHALL count 0..H_TOTAL-1 and wrap to 0; v SHALL increment when h wraps and wrap to 0 after V_TOTAL-1.
REQ-004 sync=1 SHALL force next h=0 and v=0, drive syncs inactive, drive RGB 0; sync overrides all other behaviour.
REQ-005 vga_h SHALL go active the cycle after h==H_ACTIVE+H_FP and inactive the cycle after h==H_ACTIVE+H_FP+H_SYNC.
REQ-006 vga_v SHALL change only at that same h point: active when v==V_ACTIVE+V_FP, inactive when v==V_ACTIVE+V_FP+V_SYNC.
REQ-007 RGB SHALL be registered with 1-cycle latency from pixel/h/v.
REQ-008 Channel mapping: R=pixel[4:0], G=pixel[9:5], B=pixel[14:10]; output is the top CW bits of each channel.
REQ-009 Colour priority, highest first:
- outside picture (h>=H_ACTIVE or v>=V_ACTIVE): 0;
- border=1 and (h==0, h==H_ACTIVE-1, v==0 or v==V_ACTIVE-1): all ones;
- mode result.
REQ-010 Mode 01: on odd v, each channel SHALL be shifted right by 1 before output; even lines unchanged.
REQ-011 Mode 11: pixel is ignored; output 8 vertical bars of width H_ACTIVE/8; bar n channels {R,G,B} = {n[0],n[1],n[2]} replicated to CW bits.
REQ-012 next_pixel_x SHALL equal {bank, new_h[CNT_W-2:0]}:
- new_h is next cycle's h;
- bank = bit 0 (bit 1 in mode 10) of the line new_h belongs to, i.e. v+1 when h wraps, else v;
- bank = 0 when sync=1.
REQ-013 mode SHALL be captured into a shadow register only when h and v both wrap to 0, or on sync; a mid-frame change SHALL have no effect until the next frame.

Reset
REQ-014 With rst_n low:
- h=0, v=0, shadow mode=00;
- vga_h and vga_v at inactive level (!SYNC_POL);
- RGB 0, frame_start 1.
REQ-015 Reset assertion mid-line SHALL take effect immediately, without a clock; counting SHALL resume from (0,0) on the first clk edge after release.

Structure
REQ-016 Package vga_pkg SHALL hold the mode encoding constants and the default timing constants; no other types.
REQ-017 Sub-module vga_timing SHALL hold the h/v counters, sync generation, sync restart and frame_start; colour path and mode shadow stay in the top module.

Verification
REQ-018 Defaults, reset released, pixel=15'h7FFF, mode 00, 2 frames:
- vga_h low for 82 clocks per line, starting the cycle after h==535;
- vga_v low for exactly 2 lines starting at v==490;
- frame period 682*524 clocks.
REQ-019 pixel=15'h7FFF, mode 01: v=1 RGB=4'h7 each; v=2 RGB=4'hF; h=600 RGB=0.
REQ-020 border=1, pixel=0: h=0 and h=511 give 4'hF on every visible line; h=600 on v=0 gives 0.
REQ-021 mode 10, h=681 on v=1: next_pixel_x bank=1; h=681 on v=3: bank=0. Mode 00, h=681 on v=1: bank=0.
REQ-022 Mode switched 00->11 at v=100: frame unchanged until (0,0); next frame h=64 gives R=F, G=0, B=0.
REQ-023 sync pulsed at h=300, v=200 (and rst_n pulsed mid-line): next cycle h=0, v=0, vga_h=vga_v=1, RGB=0, frame_start=1.
